// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID pipeline register, with start gating, stalls, redirects and end-of-program.
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] ST_END = 2'd2;

    localparam logic [31:0] IMEM_LIMIT   = 32'(IMEM_BYTES);
    localparam logic [31:0] PC_RESET_ALN = {PC_RESET[31:2], 2'b00};

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        pc_past_end;
    logic        target_in_range;

    logic [31:0] ins_next;
    logic [31:0] pc4_next;
    logic        valid_next;

    assign imem_addr       = pc;
    assign pc_plus4        = pc + 32'd4;
    assign target_aligned  = {branch_target[31:2], 2'b00};
    assign pc_past_end     = (pc >= IMEM_LIMIT);
    assign target_in_range = (target_aligned < IMEM_LIMIT);
    assign fetch_done      = (state == ST_END);

    // Next-state logic; IF/ID defaults to a bubble so only real captures and
    // stall holds need to override it.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ins_next   = 32'h0;
        pc4_next   = 32'h0;
        valid_next = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                if (branch_taken) begin
                    pc_next = target_aligned;
                end else if (stall) begin
                    // A flush during a stall still kills the held instruction.
                    if (!flush) begin
                        ins_next   = if_id_instruction;
                        pc4_next   = if_id_pc_plus4;
                        valid_next = if_id_valid;
                    end
                end else if (pc_past_end) begin
                    state_next = ST_END;
                end else if (flush) begin
                    pc_next = pc_plus4;
                end else begin
                    ins_next   = imem_instruction;
                    pc4_next   = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                end
            end

            ST_END: begin
                if (branch_taken && target_in_range) begin
                    pc_next    = target_aligned;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
                pc_next    = PC_RESET_ALN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            pc                <= PC_RESET_ALN;
            if_id_instruction <= 32'h0;
            if_id_pc_plus4    <= 32'h0;
            if_id_valid       <= 1'b0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            if_id_instruction <= ins_next;
            if_id_pc_plus4    <= pc4_next;
            if_id_valid       <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a vector table fed through a scoreboard
// queue, then a free-running end-of-memory sequence with a cycle budget.
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] ePc;
        logic [31:0] eIns;
        logic [31:0] ePc4;
        logic        eValid;
        logic        eDone;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_done;

    logic [31:0] mem [0:14];
    vec_t        vecs[$];
    vec_t        expQ[$];
    int          nChecks = 0;
    int          nPass   = 0;

    fetch_stage #(.PC_RESET(32'h0), .IMEM_BYTES(60)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .fetch_done       (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range reads return a poison word so an illegal capture is visible.
    always_comb begin
        if (imem_addr < 32'd60) imem_instruction = mem[imem_addr[5:2]];
        else                    imem_instruction = 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] mw(input logic [31:0] a);
        return mem[a[5:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic addVec(input logic r, input logic s, input logic st, input logic fl,
                          input logic br, input logic [31:0] tgt, input logic [31:0] ePc,
                          input logic [31:0] eIns, input logic [31:0] ePc4,
                          input logic eValid, input logic eDone);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.flush = fl; v.br = br; v.tgt = tgt;
        v.ePc = ePc; v.eIns = eIns; v.ePc4 = ePc4; v.eValid = eValid; v.eDone = eDone;
        vecs.push_back(v);
    endtask

    task automatic addBubble(input logic r, input logic s, input logic st, input logic fl,
                             input logic br, input logic [31:0] tgt, input logic [31:0] ePc,
                             input logic eDone);
        addVec(r, s, st, fl, br, tgt, ePc, 32'h0, 32'h0, 1'b0, eDone);
    endtask

    task automatic addRun(input logic [31:0] from, input logic [31:0] upto);
        for (logic [31:0] a = from; a < upto; a += 4)
            addVec(1, 0, 0, 0, 0, 0, a + 4, mw(a), a + 4, 1, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst           = v.rst;
        start         = v.start;
        stall         = v.stall;
        flush         = v.flush;
        branch_taken  = v.br;
        branch_target = v.tgt;
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (expQ.size() == 0) begin
            check($sformatf("v%0d_queue_empty", idx), 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        check($sformatf("v%0d_pc", idx),    imem_addr,         e.ePc);
        check($sformatf("v%0d_ins", idx),   if_id_instruction, e.eIns);
        check($sformatf("v%0d_pc4", idx),   if_id_pc_plus4,    e.ePc4);
        check($sformatf("v%0d_valid", idx), {31'b0, if_id_valid}, {31'b0, e.eValid});
        check($sformatf("v%0d_done", idx),  {31'b0, fetch_done},  {31'b0, e.eDone});
    endtask

    task automatic idleInputs();
        rst = 1; start = 0; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
    endtask

    initial begin
        int validCount;
        int cycles;
        logic [31:0] expPc4;

        mem[0] = 32'h2009_000A;
        for (int i = 1; i < 15; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_1111;
        idleInputs();

        // Reset, start, first capture.
        addBubble(0, 0, 0, 0, 0, 0, 32'h0, 0);
        addBubble(0, 1, 0, 0, 0, 0, 32'h0, 0);
        addBubble(1, 1, 0, 0, 0, 0, 32'h0, 0);
        addRun(32'h0, 32'h8);
        // Two-cycle stall at pc 8, then release.
        addVec(1, 0, 1, 0, 0, 0, 32'h8, mw(32'h4), 32'h8, 1, 0);
        addVec(1, 1, 1, 0, 0, 0, 32'h8, mw(32'h4), 32'h8, 1, 0);
        addRun(32'h8, 32'h30);
        // Branch wins over stall, misaligned-free target.
        addBubble(1, 0, 1, 0, 1, 32'h18, 32'h18, 0);
        addRun(32'h18, 32'h1C);
        // Flush alone, then misaligned branch target.
        addBubble(1, 0, 0, 1, 0, 0, 32'h20, 0);
        addBubble(1, 0, 0, 0, 1, 32'h1B, 32'h18, 0);
        // Straight-line to the end of memory.
        addRun(32'h18, 32'h3C);
        addBubble(1, 0, 0, 0, 0, 0, 32'h3C, 1);
        addBubble(1, 0, 0, 0, 0, 0, 32'h3C, 1);
        addBubble(1, 0, 0, 0, 1, 32'h3C, 32'h3C, 1);
        addBubble(1, 0, 0, 0, 1, 32'h40, 32'h3C, 1);
        addBubble(1, 0, 0, 0, 1, 32'h18, 32'h18, 0);
        addRun(32'h18, 32'h24);
        // Reset during a stall; fetch waits for a new start.
        addBubble(0, 0, 1, 0, 0, 0, 32'h0, 0);
        addBubble(1, 0, 0, 0, 0, 0, 32'h0, 0);
        addBubble(1, 0, 1, 1, 0, 0, 32'h0, 0);
        addBubble(1, 1, 0, 0, 0, 0, 32'h0, 0);
        addRun(32'h0, 32'h4);
        // Stall together with flush: bubble while pc holds.
        addBubble(1, 0, 1, 1, 0, 0, 32'h4, 0);
        addRun(32'h4, 32'h8);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk); #1;
            checkOutput(i);
        end

        // Free run from reset until fetch_done, within a cycle budget.
        rst = 0; @(posedge clk); #1;
        idleInputs(); start = 1; @(posedge clk); #1;
        start = 0;
        validCount = 0;
        expPc4 = 32'h4;
        cycles = 0;
        while (!fetch_done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (if_id_valid) begin
                check($sformatf("run_ins_%0d", validCount), if_id_instruction, mw(expPc4 - 4));
                check($sformatf("run_pc4_%0d", validCount), if_id_pc_plus4, expPc4);
                expPc4 += 4;
                validCount++;
            end
        end
        check("run_done_timeout", {31'b0, fetch_done}, 32'd1);
        check("run_valid_count", 32'(validCount), 32'd15);
        check("run_end_pc", imem_addr, 32'd60);
        check("run_end_bubble", {31'b0, if_id_valid}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined CPU. Owns the program counter, drives the byte address into the instruction memory and captures the returned word, with PC+4, into the IF/ID pipeline register. Handles start-up gating, hazard stalls, branch redirects, ID-stage flushes, and end-of-program detection.

Parameters:
PC_RESET, 32'h0000_0000, PC value after reset and while idle.
IMEM_BYTES, 60, instruction memory size in bytes; fetch halts once pc >= IMEM_BYTES.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low (rst == 0 resets on the clk edge).
start  in  1  program-loaded pulse/level; also wired to the instruction memory startin.
imem_addr  out  32  byte address to the instruction memory (= pc, combinational).
imem_instruction  in  32  instruction word from memory, valid in the same cycle.
stall  in  1  hazard unit: hold PC and IF/ID.
flush  in  1  ID-stage flush: bubble IF/ID this edge.
branch_taken  in  1  redirect request from the branch resolver.
branch_target  in  32  redirect byte address.
if_id_instruction  out  32  registered instruction (0 = NOP bubble).
if_id_pc_plus4  out  32  registered pc+4 of that instruction.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_done  out  1  pc is past the end of memory; only bubbles are issued.

Behaviour:
- Registers: pc[31:0], state {IDLE, FETCH, END}, IF/ID {instruction, pc_plus4, valid}.
- Reset (rst == 0 at a clk edge, in any state, including mid-stall or mid-redirect): pc = PC_RESET, state = IDLE, if_id_instruction = 0, if_id_pc_plus4 = 0, if_id_valid = 0, fetch_done = 0.
- IDLE:
  - pc is held and IF/ID carries bubbles.
  - start == 1 sampled at an edge moves to FETCH. The first instruction is captured on the following edge, because memory contents are valid only after start.
- FETCH: per-edge priority, highest first:
  1. branch_taken: pc <= {branch_target[31:2], 2'b00}; IF/ID <= bubble. This wins over stall and flush.
  2. stall: pc and IF/ID hold. A simultaneous flush still bubbles IF/ID while pc holds.
  3. flush: IF/ID <= bubble; pc <= pc + 4.
  4. Normal: IF/ID <= {imem_instruction, pc + 4, valid = 1}; pc <= pc + 4.
- Bubble definition: instruction = 32'h0, pc_plus4 = 0, valid = 0.
- PC arithmetic: 32-bit, wraps modulo 2^32, no overflow flag. pc bits [1:0] are always 0.
- End of memory:
  - While in FETCH, when pc >= IMEM_BYTES, the fetch is not captured. IF/ID <= bubble, pc holds, state <= END.
  - In END: fetch_done = 1 (registered, asserted from the edge of entry), bubbles are issued, and pc holds.
  - In END, branch_taken with aligned target < IMEM_BYTES sets pc <= target and state <= FETCH; fetch_done deasserts on that edge. Any other branch target leaves the block in END.
- The boundary is exclusive: a fetch from address IMEM_BYTES-4 is valid; a fetch from IMEM_BYTES is not.
- start is ignored outside IDLE.
- imem_addr is always pc, in every state, with no extra latency. Fetch-to-IF/ID latency is exactly 1 cycle.

Test Plan:
- Reset/start:
  - Stimulus: hold rst = 0 for 2 edges, release, start = 1 for 1 cycle, with memory word at 0 = 32'h2009000A.
  - Required: all outputs 0 during reset. One edge after start, imem_addr = 0. On the next edge, if_id_instruction = 32'h2009000A, if_id_pc_plus4 = 4, if_id_valid = 1, imem_addr = 4.
- Stall:
  - Stimulus: with pc = 8, assert stall for 2 cycles.
  - Required: pc and IF/ID (word at 4, pc_plus4 = 8) frozen for both edges. After release, IF/ID = word at 8, pc_plus4 = 12, pc = 12.
- Branch vs stall:
  - Stimulus: with pc = 0x30, assert branch_taken = 1, branch_target = 0x18, stall = 1 together.
  - Required: next edge pc = 0x18, if_id_valid = 0, if_id_instruction = 0. The edge after, IF/ID = word at 0x18, pc_plus4 = 0x1C.
- Flush and misaligned target:
  - Stimulus: flush alone at pc = 0x1C, then branch_target = 0x1B.
  - Required: after the flush, IF/ID is a bubble and pc = 0x20. After the branch, pc = 0x18.
- End of memory:
  - Stimulus: run straight-line from 0 with IMEM_BYTES = 60.
  - Required: last valid capture is the word at 56 with pc_plus4 = 60. Next edge: bubble, fetch_done = 1, pc stays 60. A later branch to 0x18 clears fetch_done and resumes fetching.
- Reset mid-operation:
  - Stimulus: rst = 0 during a stall with pc = 0x24.
  - Required: next edge pc = 0, state IDLE, IF/ID bubble. Fetch does not resume until a new start.
